// File: rtl/float_adder_arbiter_if.sv
// Bundle between the two requesters, the arbiter and the shared float adder.
// The master side (requesters and adder) drives operands, acks and add_result_i.
interface float_adder_arbiter_if;
   logic        req0_valid_i;
   logic        req0_ready_o;
   logic [31:0] req0_a_i;
   logic [31:0] req0_b_i;
   logic        req0_sub_i;
   logic        req0_done_o;
   logic        req0_ack_i;
   logic        req1_valid_i;
   logic        req1_ready_o;
   logic [31:0] req1_a_i;
   logic [31:0] req1_b_i;
   logic        req1_sub_i;
   logic        req1_done_o;
   logic        req1_ack_i;
   logic [31:0] result_o;
   logic [31:0] add_a_o;
   logic [31:0] add_b_o;
   logic        add_sub_o;
   logic [31:0] add_result_i;

   modport slave (
      input  req0_valid_i, req0_a_i, req0_b_i, req0_sub_i, req0_ack_i,
      input  req1_valid_i, req1_a_i, req1_b_i, req1_sub_i, req1_ack_i,
      input  add_result_i,
      output req0_ready_o, req0_done_o, req1_ready_o, req1_done_o,
      output result_o, add_a_o, add_b_o, add_sub_o
   );

   modport master (
      output req0_valid_i, req0_a_i, req0_b_i, req0_sub_i, req0_ack_i,
      output req1_valid_i, req1_a_i, req1_b_i, req1_sub_i, req1_ack_i,
      output add_result_i,
      input  req0_ready_o, req0_done_o, req1_ready_o, req1_done_o,
      input  result_o, add_a_o, add_b_o, add_sub_o
   );
endinterface

// File: rtl/float_adder_arbiter.sv
// Round-robin sharing of one combinational float adder between two requesters.
// Operands are held on the adder for SETTLE_CYCLES before the result is captured.
module float_adder_arbiter #(
   parameter int DATA_W        = 32,
   parameter int SETTLE_CYCLES = 1
) (
   input logic                  clk_i,
   input logic                  rst_i,
   float_adder_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, SETTLE, DONE} state_e;

   localparam logic [3:0] LAST_CNT = 4'(SETTLE_CYCLES - 1);

   state_e              state_q, state_d;
   logic                owner_q, owner_d;
   logic                last_q, last_d;
   logic [3:0]          cnt_q, cnt_d;
   logic [DATA_W-1:0]   a_q, a_d;
   logic [DATA_W-1:0]   b_q, b_d;
   logic                sub_q, sub_d;
   logic [DATA_W-1:0]   res_q, res_d;
   logic                sel;
   logic                rdy0, rdy1;
   logic                done0, done1;

   // On contention the grant goes to whoever did not win last time
   always_comb begin
      sel = 1'b0;
      if (bus.req0_valid_i && bus.req1_valid_i) begin
         sel = ~last_q;
      end else if (bus.req1_valid_i) begin
         sel = 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      sub_d   = sub_q;
      res_d   = res_q;
      rdy0    = 1'b0;
      rdy1    = 1'b0;
      done0   = 1'b0;
      done1   = 1'b0;
      unique case (state_q)
         IDLE: begin
            rdy0 = bus.req0_valid_i & ~sel;
            rdy1 = bus.req1_valid_i & sel;
            if (rdy0 || rdy1) begin
               owner_d = sel;
               last_d  = sel;
               cnt_d   = 4'd0;
               a_d     = sel ? bus.req1_a_i : bus.req0_a_i;
               b_d     = sel ? bus.req1_b_i : bus.req0_b_i;
               sub_d   = sel ? bus.req1_sub_i : bus.req0_sub_i;
               state_d = SETTLE;
            end
         end
         SETTLE: begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == LAST_CNT) begin
               res_d   = bus.add_result_i;
               state_d = DONE;
            end
         end
         DONE: begin
            done0 = ~owner_q;
            done1 = owner_q;
            if (owner_q ? bus.req1_ack_i : bus.req0_ack_i) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         owner_q <= 1'b0;
         last_q  <= 1'b1;
         cnt_q   <= 4'd0;
         a_q     <= '0;
         b_q     <= '0;
         sub_q   <= 1'b0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sub_q   <= sub_d;
         res_q   <= res_d;
      end
   end

   // Adder inputs come straight from the op regs so they stay quiet when idle
   assign bus.add_a_o      = a_q;
   assign bus.add_b_o      = b_q;
   assign bus.add_sub_o    = sub_q;
   assign bus.result_o     = res_q;
   assign bus.req0_ready_o = rdy0;
   assign bus.req1_ready_o = rdy1;
   assign bus.req0_done_o  = done0;
   assign bus.req1_done_o  = done1;
endmodule

// File: tb/tb_float_adder_arbiter.sv
// Bench for float_adder_arbiter: vector table, corner sequences and a
// randomized run against a transaction-level reference model.
module tb_float_adder_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk = 0;
   int   n_pass = 0;

   always #5 clk = ~clk;

   float_adder_arbiter_if b1();
   float_adder_arbiter_if b4();

   float_adder_arbiter #(.DATA_W(32), .SETTLE_CYCLES(1)) dut1 (
      .clk_i(clk), .rst_i(rst), .bus(b1.slave)
   );
   float_adder_arbiter #(.DATA_W(32), .SETTLE_CYCLES(4)) dut4 (
      .clk_i(clk), .rst_i(rst), .bus(b4.slave)
   );

   assign b1.add_result_i = b1.add_sub_o ? (b1.add_a_o ^ b1.add_b_o)
                                         : (b1.add_a_o | b1.add_b_o);
   assign b4.add_result_i = b4.add_sub_o ? (b4.add_a_o ^ b4.add_b_o)
                                         : (b4.add_a_o | b4.add_b_o);

   typedef struct {
      int          r;
      logic [31:0] a;
      logic [31:0] b;
      logic        s;
      logic [31:0] exp;
   } vec_t;

   vec_t        tbl [5];
   int          g [$];
   int          gc [$];
   int          lat, w, wrong, owner, bad_done;
   logic [31:0] hold_res;

   // reference model state
   int          m_left;
   logic        m_done, m_owner, m_last, m_sub;
   logic [31:0] m_a, m_b, m_res;

   function automatic logic [31:0] stub(logic [31:0] a, logic [31:0] b,
                                        logic s);
      return s ? (a ^ b) : (a | b);
   endfunction

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic idle_in();
      b1.req0_valid_i = 0; b1.req0_a_i = 0; b1.req0_b_i = 0;
      b1.req0_sub_i = 0; b1.req0_ack_i = 0;
      b1.req1_valid_i = 0; b1.req1_a_i = 0; b1.req1_b_i = 0;
      b1.req1_sub_i = 0; b1.req1_ack_i = 0;
      b4.req0_valid_i = 0; b4.req0_a_i = 0; b4.req0_b_i = 0;
      b4.req0_sub_i = 0; b4.req0_ack_i = 0;
      b4.req1_valid_i = 0; b4.req1_a_i = 0; b4.req1_b_i = 0;
      b4.req1_sub_i = 0; b4.req1_ack_i = 0;
   endtask

   task automatic set1(int r, logic v, logic [31:0] a, logic [31:0] b,
                       logic s);
      if (r == 0) begin
         b1.req0_valid_i = v; b1.req0_a_i = a;
         b1.req0_b_i = b; b1.req0_sub_i = s;
      end else begin
         b1.req1_valid_i = v; b1.req1_a_i = a;
         b1.req1_b_i = b; b1.req1_sub_i = s;
      end
   endtask

   task automatic ack1(int r, logic v);
      if (r == 0) b1.req0_ack_i = v;
      else b1.req1_ack_i = v;
   endtask

   function automatic logic rdy1(int r);
      return (r == 0) ? b1.req0_ready_o : b1.req1_ready_o;
   endfunction

   function automatic logic dn1(int r);
      return (r == 0) ? b1.req0_done_o : b1.req1_done_o;
   endfunction

   // called at a negedge; returns at negedge+1 with done seen or bound hit
   task automatic wait_done1(int r, output int l);
      l = 0;
      #1;
      while (!dn1(r) && l < 20) begin
         cyc(); l++; #1;
      end
   endtask

   task automatic run_op(vec_t v);
      int l;
      int k;
      set1(v.r, 1'b1, v.a, v.b, v.s);
      #1;
      k = 0;
      while (!rdy1(v.r) && k < 10) begin
         cyc(); k++; #1;
      end
      chk("op_ready", rdy1(v.r), 1);
      cyc();
      set1(v.r, 1'b0, v.a, v.b, v.s);
      wait_done1(v.r, l);
      chk("op_latency", l, 1);
      chk("op_result", b1.result_o, v.exp);
      chk("op_other_done", dn1(1 - v.r), 0);
      ack1(v.r, 1'b1);
      cyc();
      ack1(v.r, 1'b0);
      #1;
      chk("op_done_drop", dn1(v.r), 0);
      cyc();
   endtask

   task automatic model_reset();
      m_left = 0; m_done = 0; m_owner = 0; m_last = 1;
      m_a = 0; m_b = 0; m_sub = 0; m_res = 0;
   endtask

   initial begin
      tbl[0] = '{0, 32'h3F800000, 32'h40000000, 1'b0, 32'h7F800000};
      tbl[1] = '{1, 32'hFFFF0000, 32'h0F0F0F0F, 1'b1, 32'hF0F00F0F};
      tbl[2] = '{1, 32'h12345678, 32'h00000000, 1'b0, 32'h12345678};
      tbl[3] = '{0, 32'hAAAAAAAA, 32'h55555555, 1'b1, 32'hFFFFFFFF};
      tbl[4] = '{0, 32'h80000000, 32'h80000000, 1'b1, 32'h00000000};

      idle_in();
      rst = 1;
      cyc(); cyc();
      rst = 0;
      #1;
      chk("rst_ready0", b1.req0_ready_o, 0);
      chk("rst_done0", b1.req0_done_o, 0);
      chk("rst_done1", b1.req1_done_o, 0);
      chk("rst_result", b1.result_o, 0);
      chk("rst_add_a", b1.add_a_o, 0);
      chk("rst_add_b", b1.add_b_o, 0);
      chk("rst_add_sub", b1.add_sub_o, 0);
      chk("rst4_result", b4.result_o, 0);
      cyc();

      for (int i = 0; i < 5; i++) run_op(tbl[i]);

      // contention with immediate acks: strict alternation, 3-cycle issue
      rst = 1; cyc(); rst = 0;
      b1.req0_valid_i = 1; b1.req1_valid_i = 1;
      b1.req0_ack_i = 1; b1.req1_ack_i = 1;
      b1.req0_a_i = 32'h1; b1.req1_a_i = 32'h2;
      wrong = 0; owner = -1;
      for (int c = 0; c < 30 && g.size() < 4; c++) begin
         #1;
         if (b1.req0_done_o && owner != 0) wrong++;
         if (b1.req1_done_o && owner != 1) wrong++;
         if (b1.req0_ready_o && b1.req1_ready_o) wrong++;
         if (b1.req0_ready_o || b1.req1_ready_o) begin
            owner = b1.req1_ready_o ? 1 : 0;
            g.push_back(owner);
            gc.push_back(c);
         end
         cyc();
      end
      chk("alt_count", g.size(), 4);
      for (int i = 0; i < g.size(); i++) chk("alt_grant", g[i], i % 2);
      for (int i = 1; i < gc.size(); i++)
         chk("alt_interval", gc[i] - gc[i-1], 3);
      b1.req0_valid_i = 0; b1.req1_valid_i = 0;
      for (int i = 0; i < 4; i++) begin
         #1;
         if (b1.req0_done_o && owner != 0) wrong++;
         if (b1.req1_done_o && owner != 1) wrong++;
         cyc();
      end
      chk("alt_wrong_done", wrong, 0);
      idle_in();
      cyc();

      // ack held off in DONE while req1 waits
      set1(0, 1'b1, 32'h00F0F000, 32'h0000000F, 1'b0);
      #1;
      chk("hold_ready0", b1.req0_ready_o, 1);
      cyc();
      b1.req0_valid_i = 0;
      wait_done1(0, lat);
      chk("hold_latency", lat, 1);
      hold_res = b1.result_o;
      chk("hold_result", hold_res, 32'h00F0F00F);
      b1.req1_valid_i = 1;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("hold_done0", b1.req0_done_o, 1);
         chk("hold_result_stable", b1.result_o, hold_res);
         chk("hold_ready1", b1.req1_ready_o, 0);
         cyc();
      end
      b1.req0_ack_i = 1;
      cyc();
      b1.req0_ack_i = 0;
      #1;
      chk("hold_done0_drop", b1.req0_done_o, 0);
      chk("hold_ready1_idle", b1.req1_ready_o, 1);
      b1.req1_valid_i = 0;
      cyc();

      // non-owner ack ignored; valid dropped before ready
      set1(0, 1'b1, 32'hC0000000, 32'h00000003, 1'b1);
      #1;
      chk("nack_ready0", b1.req0_ready_o, 1);
      cyc();
      b1.req0_valid_i = 0;
      wait_done1(0, lat);
      chk("nack_done0", b1.req0_done_o, 1);
      b1.req1_ack_i = 1;
      cyc();
      b1.req1_ack_i = 0;
      #1;
      chk("nack_done0_stays", b1.req0_done_o, 1);
      b1.req1_valid_i = 1;
      #1;
      chk("nack_ready1_busy", b1.req1_ready_o, 0);
      b1.req1_valid_i = 0;
      b1.req0_ack_i = 1;
      cyc();
      b1.req0_ack_i = 0;
      #1;
      chk("drop_ready0", b1.req0_ready_o, 0);
      chk("drop_ready1", b1.req1_ready_o, 0);
      chk("drop_done0", b1.req0_done_o, 0);
      chk("drop_add_a_held", b1.add_a_o, 32'hC0000000);
      cyc();
      b1.req0_valid_i = 1;
      #1;
      chk("drop_still_idle", b1.req0_ready_o, 1);
      b1.req0_valid_i = 0;
      cyc();

      // SETTLE_CYCLES=4: adder inputs stable, capture at cycle 4
      b4.req0_valid_i = 1; b4.req0_a_i = 32'hFFFF0000;
      b4.req0_b_i = 32'h0F0F0F0F; b4.req0_sub_i = 1;
      #1;
      chk("s4_ready0", b4.req0_ready_o, 1);
      cyc();
      b4.req0_valid_i = 0; b4.req0_a_i = 0; b4.req0_b_i = 0;
      b4.req0_sub_i = 0;
      for (int i = 1; i <= 4; i++) begin
         #1;
         chk("s4_add_a", b4.add_a_o, 32'hFFFF0000);
         chk("s4_add_b", b4.add_b_o, 32'h0F0F0F0F);
         chk("s4_add_sub", b4.add_sub_o, 1);
         chk("s4_no_done", b4.req0_done_o, 0);
         chk("s4_result_old", b4.result_o, 0);
         cyc();
      end
      #1;
      chk("s4_done", b4.req0_done_o, 1);
      chk("s4_result", b4.result_o, 32'hF0F00F0F);
      b4.req0_ack_i = 1;
      cyc();
      b4.req0_ack_i = 0;
      cyc();

      // reset during SETTLE
      b4.req0_valid_i = 1; b4.req0_a_i = 32'h1; b4.req0_b_i = 32'h2;
      #1;
      chk("rs_ready0", b4.req0_ready_o, 1);
      cyc();
      b4.req0_valid_i = 0;
      rst = 1;
      cyc();
      rst = 0;
      #1;
      chk("rs_add_a", b4.add_a_o, 0);
      chk("rs_result", b4.result_o, 0);
      bad_done = 0;
      for (int i = 0; i < 6; i++) begin
         #1;
         if (b4.req0_done_o || b4.req1_done_o) bad_done++;
         cyc();
      end
      chk("rs_no_done", bad_done, 0);

      // reset during DONE
      b4.req0_valid_i = 1; b4.req0_a_i = 32'h10; b4.req0_b_i = 32'h01;
      cyc();
      b4.req0_valid_i = 0;
      w = 0;
      #1;
      while (!b4.req0_done_o && w < 20) begin
         cyc(); w++; #1;
      end
      chk("rd_done_seen", b4.req0_done_o, 1);
      chk("rd_latency", w, 4);
      rst = 1;
      cyc();
      rst = 0;
      #1;
      chk("rd_done_gone", b4.req0_done_o, 0);
      chk("rd_result", b4.result_o, 0);
      chk("rd_add_a", b4.add_a_o, 0);

      // reset wins over accept, then req0 wins the tie
      b4.req0_valid_i = 1; b4.req1_valid_i = 1;
      b4.req0_a_i = 32'h5; b4.req1_a_i = 32'h6;
      rst = 1;
      cyc();
      rst = 0;
      #1;
      chk("rw_add_a", b4.add_a_o, 0);
      chk("rw_tie_ready0", b4.req0_ready_o, 1);
      chk("rw_tie_ready1", b4.req1_ready_o, 0);
      idle_in();
      cyc();

      // randomized run against the transaction model
      rst = 1; cyc(); rst = 0;
      model_reset();
      for (int c = 0; c < 600; c++) begin
         logic er0, er1, idle, acc;
         rst = ($urandom_range(0, 59) == 0);
         b1.req0_valid_i = $urandom_range(0, 1);
         b1.req1_valid_i = $urandom_range(0, 1);
         b1.req0_ack_i   = $urandom_range(0, 1);
         b1.req1_ack_i   = $urandom_range(0, 1);
         b1.req0_a_i = $urandom; b1.req0_b_i = $urandom;
         b1.req0_sub_i = $urandom_range(0, 1);
         b1.req1_a_i = $urandom; b1.req1_b_i = $urandom;
         b1.req1_sub_i = $urandom_range(0, 1);
         idle = (m_left == 0) && !m_done;
         er0 = idle && b1.req0_valid_i && (!b1.req1_valid_i || m_last);
         er1 = idle && b1.req1_valid_i && (!b1.req0_valid_i || !m_last);
         #1;
         chk("rnd_ready0", b1.req0_ready_o, er0);
         chk("rnd_ready1", b1.req1_ready_o, er1);
         chk("rnd_done0", b1.req0_done_o, m_done && !m_owner);
         chk("rnd_done1", b1.req1_done_o, m_done && m_owner);
         chk("rnd_result", b1.result_o, m_res);
         chk("rnd_adder", {b1.add_sub_o, b1.add_a_o, b1.add_b_o},
             {m_sub, m_a, m_b});
         acc = er0 || er1;
         if (rst) begin
            model_reset();
         end else if (acc) begin
            m_owner = er1; m_last = er1; m_left = 1;
            m_a   = er1 ? b1.req1_a_i : b1.req0_a_i;
            m_b   = er1 ? b1.req1_b_i : b1.req0_b_i;
            m_sub = er1 ? b1.req1_sub_i : b1.req0_sub_i;
         end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
               m_res = stub(m_a, m_b, m_sub);
               m_done = 1;
            end
         end else if (m_done && (m_owner ? b1.req1_ack_i : b1.req0_ack_i)) begin
            m_done = 0;
         end
         cyc();
      end
      rst = 0;
      idle_in();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
